// File: rtl/mem_arbiter_if.sv
// Bundle of fetch port, data port and shared memory signals for mem_arbiter.
// slave  : arbiter side (takes requests and mem_rdata, drives grants/responses/memory strobes).
// master : requester/memory side (drives requests and mem_rdata).
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              f_req;
    logic [63:0]       f_addr;
    logic              f_gnt;
    logic              f_rvalid;
    logic [63:0]       f_rdata;
    logic              f_err;

    logic              d_req;
    logic              d_we;
    logic [63:0]       d_addr;
    logic [63:0]       d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic              d_err;
    logic [63:0]       d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [63:0]       mem_wdata;
    logic [63:0]       mem_rdata;

    modport slave (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output f_gnt, f_rvalid, f_rdata, f_err,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  f_gnt, f_rvalid, f_rdata, f_err,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single-ported data memory.
// Ports:
//   clk   : single clock, all state updates on posedge
//   rst_n : synchronous active-low reset
//   bus   : mem_arbiter_if.slave -- fetch request/response, data request/response,
//           memory strobes (mem_en/mem_we/mem_addr/mem_wdata) and mem_rdata
// Grants and memory strobes are combinational from state and requests; read
// responses and errors are decoded from registered state only.
module mem_arbiter #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RESP_F = 2'd1;
    localparam logic [1:0] RESP_D = 2'd2;

    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] starve_cnt, starve_nxt;
    logic             oor_q, oor_nxt;        // in-flight read was out of range
    logic             wr_err_q, wr_err_nxt;  // out-of-range write error pulse

    logic              f_gnt, d_gnt;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [63:0]       mem_wdata;

    logic f_inr, d_inr;
    logic starved;

    assign f_inr   = (bus.f_addr[63:ADDR_W] == '0);
    assign d_inr   = (bus.d_addr[63:ADDR_W] == '0);
    assign starved = (starve_cnt == CNT_W'(STARVE_MAX));

    // Next-state, grant and memory strobe decode
    always_comb begin
        state_nxt  = state;
        starve_nxt = starve_cnt;
        oor_nxt    = 1'b0;
        wr_err_nxt = 1'b0;
        f_gnt      = 1'b0;
        d_gnt      = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;

        case (state)
            IDLE: begin
                // Data wins contention unless fetch has lost STARVE_MAX times in a row
                if (bus.d_req && !(bus.f_req && starved)) begin
                    d_gnt = rst_n;
                end else if (bus.f_req) begin
                    f_gnt = rst_n;
                end
            end
            RESP_F, RESP_D: state_nxt = IDLE;
            default:        state_nxt = IDLE;
        endcase

        if (f_gnt) begin
            mem_en     = f_inr;
            mem_addr   = bus.f_addr[ADDR_W-1:0];
            state_nxt  = RESP_F;
            oor_nxt    = !f_inr;
            starve_nxt = '0;
        end

        if (d_gnt) begin
            mem_en   = d_inr;
            mem_we   = d_inr && bus.d_we;
            mem_addr = bus.d_addr[ADDR_W-1:0];
            if (bus.d_we) begin
                mem_wdata  = d_inr ? bus.d_wdata : '0;
                wr_err_nxt = !d_inr;
            end else begin
                state_nxt = RESP_D;
                oor_nxt   = !d_inr;
            end
            if (bus.f_req && !starved) begin
                starve_nxt = starve_cnt + CNT_W'(1);
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            starve_cnt <= '0;
            oor_q      <= 1'b0;
            wr_err_q   <= 1'b0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            oor_q      <= oor_nxt;
            wr_err_q   <= wr_err_nxt;
        end
    end

    assign bus.f_gnt     = f_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.mem_en    = mem_en;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;

    // Responses: state-decoded, forced low while reset is asserted
    assign bus.f_rvalid = rst_n && (state == RESP_F);
    assign bus.d_rvalid = rst_n && (state == RESP_D);
    assign bus.f_err    = bus.f_rvalid && oor_q;
    assign bus.d_err    = rst_n && (((state == RESP_D) && oor_q) || wr_err_q);
    assign bus.f_rdata  = (bus.f_rvalid && !oor_q) ? bus.mem_rdata : '0;
    assign bus.d_rdata  = (bus.d_rvalid && !oor_q) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios followed by random traffic
// on both ports, checked against a rule-level reference model.
module tb_mem_arbiter;

    localparam int unsigned ADDR_W     = 10;
    localparam int unsigned STARVE_MAX = 4;
    localparam int unsigned DEPTH      = 1 << ADDR_W;

    typedef struct packed {
        logic        rvalid;
        logic        err;
        logic [63:0] rdata;
    } resp_t;

    logic clk = 1'b0;
    logic rst_n;

    mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    mem_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [63:0] mem_array [DEPTH];   // memory device behind the arbiter
    logic [63:0] ref_mem   [DEPTH];   // reference view of memory contents
    resp_t fq[$];
    resp_t dq[$];
    logic  busy_m = 1'b0;
    int    lose_m = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic in_range(input logic [63:0] a);
        return (a >> ADDR_W) == 64'd0;
    endfunction

    // Memory device: writes land at the edge, read data appears the next cycle
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem_array[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata <= mem_array[bus.mem_addr];
        end
    end

    // Monitor + reference model, sampled on the inactive edge
    always @(negedge clk) begin
        resp_t e;
        logic  ef, ed, ren, rwe, finr, dinr;
        if (!rst_n) begin
            chk("reset_outputs",
                128'({bus.f_gnt, bus.d_gnt, bus.f_rvalid, bus.d_rvalid, bus.f_err, bus.d_err,
                      bus.mem_en, bus.mem_we, bus.mem_addr}), 128'd0);
            chk("reset_data", {bus.f_rdata | bus.d_rdata, bus.mem_wdata}, 128'd0);
            fq.delete();
            dq.delete();
            busy_m = 1'b0;
            lose_m = 0;
        end else begin
            if (fq.size() > 0 || bus.f_rvalid || bus.f_err) begin
                e = (fq.size() > 0) ? fq.pop_front() : '0;
                chk("f_resp", 128'({bus.f_rvalid, bus.f_err, bus.f_rdata}), 128'(e));
            end
            if (dq.size() > 0 || bus.d_rvalid || bus.d_err) begin
                e = (dq.size() > 0) ? dq.pop_front() : '0;
                chk("d_resp", 128'({bus.d_rvalid, bus.d_err, bus.d_rdata}), 128'(e));
            end

            ef = 1'b0;
            ed = 1'b0;
            if (!busy_m) begin
                if (bus.f_req && bus.d_req) begin
                    if (lose_m == STARVE_MAX) ef = 1'b1;
                    else                      ed = 1'b1;
                end else begin
                    ef = bus.f_req;
                    ed = bus.d_req;
                end
            end
            chk("grants", 128'({bus.f_gnt, bus.d_gnt}), 128'({ef, ed}));

            finr = in_range(bus.f_addr);
            dinr = in_range(bus.d_addr);
            ren  = (ef && finr) || (ed && dinr);
            rwe  = ed && dinr && bus.d_we;
            chk("mem_strobe", 128'({bus.mem_en, bus.mem_we}), 128'({ren, rwe}));
            if (ren) chk("mem_addr", 128'(bus.mem_addr),
                         128'(ef ? bus.f_addr[ADDR_W-1:0] : bus.d_addr[ADDR_W-1:0]));
            if (rwe) chk("mem_wdata", 128'(bus.mem_wdata), 128'(bus.d_wdata));

            if (ef) begin
                fq.push_back('{1'b1, !finr, finr ? ref_mem[bus.f_addr[ADDR_W-1:0]] : 64'd0});
                lose_m = 0;
            end
            if (ed) begin
                if (!bus.d_we)  dq.push_back('{1'b1, !dinr, dinr ? ref_mem[bus.d_addr[ADDR_W-1:0]] : 64'd0});
                else if (!dinr) dq.push_back('{1'b0, 1'b1, 64'd0});
                else            ref_mem[bus.d_addr[ADDR_W-1:0]] = bus.d_wdata;
                if (bus.f_req && lose_m < STARVE_MAX) lose_m++;
            end
            busy_m = ef || (ed && !bus.d_we);
        end
    end

    task automatic d_issue(input logic we, input logic [63:0] addr, input logic [63:0] wdata);
        int n = 0;
        bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
        forever begin
            @(negedge clk);
            if (bus.d_gnt) break;
            if (++n >= 100) begin chk("d_gnt_timeout", 128'd0, 128'd1); break; end
        end
        @(posedge clk); #1;
        bus.d_req = 1'b0;
    endtask

    task automatic f_issue(input logic [63:0] addr);
        int n = 0;
        bus.f_req = 1'b1; bus.f_addr = addr;
        forever begin
            @(negedge clk);
            if (bus.f_gnt) break;
            if (++n >= 100) begin chk("f_gnt_timeout", 128'd0, 128'd1); break; end
        end
        @(posedge clk); #1;
        bus.f_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    function automatic logic [63:0] rand_addr();
        int r = $urandom_range(0, 9);
        if (r == 0) return 64'd1024 + 64'($urandom_range(0, 3));
        if (r == 1) return {$urandom, $urandom};
        return 64'($urandom_range(0, 15));
    endfunction

    initial begin
        rst_n = 1'b0;
        bus.f_req = 1'b0; bus.f_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.mem_rdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mem_array[i] = {$urandom, $urandom};
            ref_mem[i]   = mem_array[i];
        end
        mem_array[4] = 64'd2;
        ref_mem[4]   = 64'd2;
        idle(3);
        rst_n = 1'b1;
        idle(1);

        // Basic read, write-then-read back-to-back, out-of-range read and write
        d_issue(1'b0, 64'd4, 64'd0);
        d_issue(1'b1, 64'd12, 64'd7);
        d_issue(1'b0, 64'd12, 64'd0);
        d_issue(1'b0, 64'd1024, 64'd0);
        d_issue(1'b1, 64'd1024, 64'd99);
        d_issue(1'b0, 64'd0, 64'd0);
        idle(2);

        // Continuous contention: fetch must win after STARVE_MAX losses
        fork
            for (int i = 0; i < 3; i++) f_issue(64'(i + 20));
            for (int i = 0; i < 12; i++) d_issue(1'b0, 64'(i), 64'd0);
        join
        idle(2);

        // Fetch pulse while a data read is in flight is dropped
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 64'd5;
        @(posedge clk); #1;
        bus.d_req = 1'b0;
        bus.f_req = 1'b1; bus.f_addr = 64'd6;
        @(posedge clk); #1;
        bus.f_req = 1'b0;
        idle(2);

        // Random traffic on both ports, including abandoned data requests
        fork
            for (int i = 0; i < 150; i++) begin
                idle($urandom_range(0, 3));
                f_issue(rand_addr());
            end
            for (int i = 0; i < 150; i++) begin
                idle($urandom_range(0, 3));
                if ($urandom_range(0, 7) == 0) begin
                    bus.d_req = 1'b1; bus.d_we = 1'($urandom); bus.d_addr = rand_addr();
                    bus.d_wdata = {$urandom, $urandom};
                    @(posedge clk); #1;
                    bus.d_req = 1'b0;
                end else begin
                    d_issue(1'($urandom), rand_addr(), {$urandom, $urandom});
                end
            end
        join
        idle(2);

        // Reset during a data read response: no rvalid, arbitration history cleared
        fork
            for (int i = 0; i < 3; i++) f_issue(64'd30);
            for (int i = 0; i < 3; i++) d_issue(1'b0, 64'd31, 64'd0);
        join
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 64'd3;
        @(posedge clk); #1;
        bus.d_req = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);
        fork
            for (int i = 0; i < 2; i++) f_issue(64'd40);
            for (int i = 0; i < 8; i++) d_issue(1'b0, 64'(i + 41), 64'd0);
        join
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
